counter_cmd_sched: RTL

//  Merges debounced button pulses and UART RX command bytes into single-cycle run/clear/mode

---
 rtl/counter_cmd_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/counter_cmd_sched.sv
// Command scheduler for the 0..9999 counter: merges button and UART commands into prioritised
// single-cycle strobes, and answers a UART status request with "dddd\r\n".
module counter_cmd_sched #(
  parameter bit CASE_INSENS = 1'b1,
  parameter bit SEND_CRLF   = 1'b1,
  parameter int BUSY_WAIT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_clear,
  input  logic        btn_mode,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic [13:0] counter,
  input  logic        tx_busy,
  output logic        cmd_run,
  output logic        cmd_clear,
  output logic        cmd_mode,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        rpt_busy
);

  typedef enum logic [1:0] {IDLE, CONV, SEND, WAIT} state_t;

  localparam int         WW   = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT + 1);
  localparam logic [2:0] LAST = SEND_CRLF ? 3'd5 : 3'd3;

  // One double-dabble iteration on {bcd[15:0], bin[13:0]}: add-3 to digits >= 5, then shift.
  function automatic logic [29:0] dd_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int k = 0; k < 4; k++) begin
      if (t[14+4*k +: 4] >= 4'd5) t[14+4*k +: 4] = t[14+4*k +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  function automatic logic [7:0] char_of(input logic [2:0] idx, input logic [15:0] bcd);
    case (idx)
      3'd0:    char_of = {4'h3, bcd[15:12]};
      3'd1:    char_of = {4'h3, bcd[11:8]};
      3'd2:    char_of = {4'h3, bcd[7:4]};
      3'd3:    char_of = {4'h3, bcd[3:0]};
      3'd4:    char_of = 8'h0D;
      default: char_of = 8'h0A;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic          pend_run_q, pend_run_d, pend_clear_q, pend_clear_d, pend_mode_q, pend_mode_d;
  logic [29:0]   sh_q, sh_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          seen_q, seen_d;
  logic          txs_q, txs_d;
  logic [7:0]    txd_q, txd_d;
  logic          hit_r, hit_c, hit_m, hit_s;
  logic          iss_run, iss_clear, iss_mode;

  always_comb begin
    hit_r = rx_done && (rx_data == 8'h52 || (CASE_INSENS && rx_data == 8'h72));
    hit_c = rx_done && (rx_data == 8'h43 || (CASE_INSENS && rx_data == 8'h63));
    hit_m = rx_done && (rx_data == 8'h4D || (CASE_INSENS && rx_data == 8'h6D));
    hit_s = rx_done && (rx_data == 8'h53 || (CASE_INSENS && rx_data == 8'h73));
  end

  // Fixed priority clear > run > mode; a request landing in its own issue cycle re-arms the flag.
  always_comb begin
    iss_clear    = pend_clear_q;
    iss_run      = pend_run_q & ~pend_clear_q;
    iss_mode     = pend_mode_q & ~pend_clear_q & ~pend_run_q;
    pend_clear_d = (pend_clear_q & ~iss_clear) | btn_clear | hit_c;
    pend_run_d   = (pend_run_q & ~iss_run) | btn_run | hit_r;
    pend_mode_d  = (pend_mode_q & ~iss_mode) | btn_mode | hit_m;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    seen_d  = seen_q;
    txs_d   = 1'b0;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          sh_d    = {16'd0, (counter > 14'd9999) ? 14'd9999 : counter};
          cnt_d   = 4'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d = dd_step(sh_q);
        if (cnt_q == 4'd13) begin
          idx_d   = 3'd0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          txs_d   = 1'b1;
          txd_d   = char_of(idx_q, sh_q[29:14]);
          wcnt_d  = '0;
          seen_d  = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // First wait for the transmitter to take the byte (or give up), then for it to finish.
        if (!seen_q) begin
          if (tx_busy || wcnt_q == WW'(BUSY_WAIT)) seen_d = 1'b1;
          else wcnt_d = wcnt_q + 1'b1;
        end else if (!tx_busy) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pend_run_q   <= 1'b0;
      pend_clear_q <= 1'b0;
      pend_mode_q  <= 1'b0;
      sh_q         <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      wcnt_q       <= '0;
      seen_q       <= 1'b0;
      txs_q        <= 1'b0;
      txd_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_run_q   <= pend_run_d;
      pend_clear_q <= pend_clear_d;
      pend_mode_q  <= pend_mode_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      seen_q       <= seen_d;
      txs_q        <= txs_d;
      txd_q        <= txd_d;
    end
  end

  assign cmd_clear = iss_clear;
  assign cmd_run   = iss_run;
  assign cmd_mode  = iss_mode;
  assign tx_start  = txs_q;
  assign tx_data   = txd_q;
  assign rpt_busy  = (state_q != IDLE);

endmodule
